sim_exit_monitor: RTL and testbench

- Simulation-side responder that watches the RS5 data-memory write port for the end-of-test handshake the program issues.
- Captures the exit code and drives pass/fail, done and timeout flags back to the bench, which uses them to stop simulation and report.
- Also counts run cycles, so the bench stops hung programs after a bounded time.
- Sits beside the data RAM model in the testbench, on the same clock and reset the bench generates.

---
 rtl/sim_exit_monitor.sv | 146 ++++++++++++++
 tb/tb_sim_exit_monitor.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sim_exit_monitor.sv
// End-of-test monitor: watches the data-memory write port for the exit handshake,
// drains in-flight stores, then reports done/pass/timeout. Optional console: SIM_EXIT_CONSOLE_EN.
module sim_exit_monitor #(
  parameter logic [31:0] EXIT_ADDR      = 32'h8000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned DRAIN_CYCLES   = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        enable_i,
  input  logic        mem_operation_enable_i,
  input  logic [3:0]  mem_write_enable_i,
  input  logic [31:0] mem_address_i,
  input  logic [31:0] mem_data_i,
  output logic        done_o,
  output logic        pass_o,
  output logic        timeout_o,
  output logic [30:0] exit_code_o,
`ifdef SIM_EXIT_CONSOLE_EN
  output logic        char_valid_o,
  output logic [7:0]  char_o,
`endif
  output logic [31:0] cycle_count_o
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RUN     = 3'd1,
    ST_DRAIN   = 3'd2,
    ST_DONE    = 3'd3,
    ST_TIMEOUT = 3'd4
  } state_e;

  localparam logic [31:0] CONSOLE_ADDR = EXIT_ADDR + 32'd4;

  state_e      state_q, state_d;
  logic [31:0] count_q, count_d;
  logic [31:0] drain_q, drain_d;
  logic [30:0] code_q, code_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic        timeout_q, timeout_d;
  logic        exit_wr;
  logic [31:0] count_inc;
  logic        unused_addr_bits;

  // Word-granular match: the low address bits carry no meaning for either register.
  assign unused_addr_bits = ^mem_address_i[1:0];
  assign exit_wr = mem_operation_enable_i && (mem_write_enable_i == 4'b1111) &&
                   (mem_address_i[31:2] == EXIT_ADDR[31:2]) && mem_data_i[0];
  assign count_inc = (&count_q) ? count_q : count_q + 32'd1;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      drain_q   <= '0;
      code_q    <= '0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      drain_q   <= drain_d;
      code_q    <= code_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    drain_d = drain_q;
    code_d  = code_q;
    case (state_q)
      ST_IDLE: begin
        count_d = '0;
        drain_d = '0;
        if (enable_i) state_d = ST_RUN;
      end
      ST_RUN: begin
        drain_d = '0;
        // The exit write wins over a timeout landing on the same cycle.
        if (exit_wr) begin
          code_d  = mem_data_i[31:1];
          count_d = count_inc;
          state_d = ST_DRAIN;
        end else if (count_q == TIMEOUT_CYCLES - 1) begin
          state_d = ST_TIMEOUT;
        end else begin
          count_d = count_inc;
        end
      end
      ST_DRAIN: begin
        if (drain_q == DRAIN_CYCLES - 1) state_d = ST_DONE;
        else drain_d = drain_q + 32'd1;
      end
      default: ;
    endcase
  end

  // Flags follow the terminal state one edge later; both terminal states are sticky.
  always_comb begin
    done_d    = (state_q == ST_DONE) || (state_q == ST_TIMEOUT);
    pass_d    = (state_q == ST_DONE) && (code_q == '0);
    timeout_d = (state_q == ST_TIMEOUT);
  end

`ifdef SIM_EXIT_CONSOLE_EN
  logic       char_valid_q, char_valid_d;
  logic [7:0] char_q, char_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      char_valid_q <= 1'b0;
      char_q       <= '0;
    end else begin
      char_valid_q <= char_valid_d;
      char_q       <= char_d;
    end
  end

  always_comb begin
    char_valid_d = mem_operation_enable_i && mem_write_enable_i[0] &&
                   (mem_address_i[31:2] == CONSOLE_ADDR[31:2]) &&
                   ((state_q == ST_RUN) || (state_q == ST_DRAIN));
    char_d = char_valid_d ? mem_data_i[7:0] : char_q;
  end

  assign char_valid_o = char_valid_q;
  assign char_o       = char_q;
`else
  logic unused_console_addr;
  assign unused_console_addr = ^CONSOLE_ADDR;
`endif

  assign done_o        = done_q;
  assign pass_o        = pass_q;
  assign timeout_o     = timeout_q;
  assign exit_code_o   = code_q;
  assign cycle_count_o = count_q;

endmodule

// File: tb/tb_sim_exit_monitor.sv
// Self-checking bench for sim_exit_monitor: directed end-of-test scenarios plus
// randomized bus traffic compared against an event-timed reference model.
module tb_sim_exit_monitor;

  localparam logic [31:0] EXIT_ADDR = 32'h8000_0000;
  localparam int          T_CYC     = 60;
  localparam int          D_CYC     = 4;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        enable_i;
  logic        op_i;
  logic [3:0]  we_i;
  logic [31:0] addr_i;
  logic [31:0] data_i;
  logic        done_o, pass_o, timeout_o;
  logic [30:0] exit_code_o;
  logic [31:0] cycle_count_o;
`ifdef SIM_EXIT_CONSOLE_EN
  logic        char_valid_o;
  logic [7:0]  char_o;
  logic [7:0]  exp_q[$];
`endif

  int checks   = 0;
  int failures = 0;

  // Reference model: run progress as plain counters and edge timestamps.
  int          m_edge;
  int          m_phase;   // 0 not armed, 1 running, 2 run ended
  int          m_end;     // edge at which the run ended
  bit          m_to;      // run ended by timeout
  bit          m_cv;
  logic [31:0] m_count;
  logic [30:0] m_code;

  sim_exit_monitor #(
    .EXIT_ADDR      (EXIT_ADDR),
    .TIMEOUT_CYCLES (T_CYC),
    .DRAIN_CYCLES   (D_CYC)
  ) dut (
    .clk_i                  (clk),
    .rst_i                  (rst_i),
    .enable_i               (enable_i),
    .mem_operation_enable_i (op_i),
    .mem_write_enable_i     (we_i),
    .mem_address_i          (addr_i),
    .mem_data_i             (data_i),
    .done_o                 (done_o),
    .pass_o                 (pass_o),
    .timeout_o              (timeout_o),
    .exit_code_o            (exit_code_o),
`ifdef SIM_EXIT_CONSOLE_EN
    .char_valid_o           (char_valid_o),
    .char_o                 (char_o),
`endif
    .cycle_count_o          (cycle_count_o)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_exit_wr();
    return op_i && (we_i == 4'hF) && (addr_i[31:2] == EXIT_ADDR[31:2]) && data_i[0];
  endfunction

  function automatic bit is_console_wr();
    logic [31:0] con;
    con = EXIT_ADDR + 32'd4;
    return op_i && we_i[0] && (addr_i[31:2] == con[31:2]);
  endfunction

  // Advance the model by one edge using the inputs about to be sampled.
  task automatic model_update();
    bit con;
    con = is_console_wr();
    m_edge++;
    m_cv = 1'b0;
    if (rst_i) begin
      m_phase = 0; m_count = '0; m_code = '0; m_to = 1'b0; m_end = 0;
`ifdef SIM_EXIT_CONSOLE_EN
      exp_q.delete();
`endif
    end else if (m_phase == 0) begin
      if (enable_i) begin m_phase = 1; m_count = '0; end
    end else if (m_phase == 1) begin
      m_cv = con;
      if (is_exit_wr()) begin
        m_code  = data_i[31:1];
        m_count = (m_count == 32'hFFFF_FFFF) ? m_count : m_count + 1;
        m_phase = 2; m_end = m_edge; m_to = 1'b0;
      end else if (m_count == 32'(T_CYC - 1)) begin
        m_phase = 2; m_end = m_edge; m_to = 1'b1;
      end else begin
        m_count = (m_count == 32'hFFFF_FFFF) ? m_count : m_count + 1;
      end
    end else begin
      // Draining window: edges end+1 .. end+D sample writes while still in DRAIN.
      m_cv = con && !m_to && (m_edge <= m_end + D_CYC);
    end
`ifdef SIM_EXIT_CONSOLE_EN
    if (m_cv) exp_q.push_back(data_i[7:0]);
`endif
  endtask

  task automatic compare_all();
    bit to_done, ex_done;
    to_done = (m_phase == 2) && m_to && (m_edge >= m_end + 1);
    ex_done = (m_phase == 2) && !m_to && (m_edge >= m_end + D_CYC + 1);
    check("done",      32'(done_o),      32'(to_done || ex_done));
    check("pass",      32'(pass_o),      32'(ex_done && (m_code == '0)));
    check("timeout",   32'(timeout_o),   32'(to_done));
    check("exit_code", 32'(exit_code_o), 32'(m_code));
    check("cycles",    cycle_count_o,    m_count);
`ifdef SIM_EXIT_CONSOLE_EN
    check("char_valid", 32'(char_valid_o), 32'(m_cv));
    if (char_valid_o) begin
      if (exp_q.size() == 0) check("char_unexpected", 32'(char_o), 32'hFFFF_FFFF);
      else check("char", 32'(char_o), 32'(exp_q.pop_front()));
    end
`endif
  endtask

  task automatic step();
    model_update();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic bus_idle();
    op_i = 1'b0; we_i = 4'h0; addr_i = '0; data_i = '0;
  endtask

  task automatic do_reset(input int n);
    rst_i = 1'b1;
    bus_idle();
    repeat (n) step();
    rst_i = 1'b0;
  endtask

  task automatic run_idle(input int n);
    bus_idle();
    repeat (n) step();
  endtask

  task automatic bus_write(input logic [3:0] we, input logic [31:0] addr, input logic [31:0] data);
    op_i = 1'b1; we_i = we; addr_i = addr; data_i = data;
    step();
    bus_idle();
  endtask

  task automatic rand_bus();
    int sel;
    op_i = ($urandom_range(0, 3) != 0);
    sel = $urandom_range(0, 9);
    if (sel < 4)      addr_i = EXIT_ADDR | 32'($urandom_range(0, 3));
    else if (sel < 6) addr_i = EXIT_ADDR + 32'd4 + 32'($urandom_range(0, 3));
    else if (sel < 7) addr_i = EXIT_ADDR + 32'd8;
    else              addr_i = $urandom;
    case ($urandom_range(0, 4))
      0: we_i = 4'h0;
      1: we_i = 4'hF;
      2: we_i = 4'h1;
      3: we_i = 4'h3;
      default: we_i = 4'($urandom_range(0, 15));
    endcase
    data_i = ($urandom_range(0, 3) == 0) ? 32'h1 : $urandom;
  endtask

  initial begin
    m_edge = 0; m_phase = 0; m_end = 0; m_to = 1'b0; m_cv = 1'b0;
    m_count = '0; m_code = '0;
    enable_i = 1'b1;

    // Pass run: exit write at RUN cycle 50, done five edges later.
    do_reset(10);
    check("rst_done", 32'(done_o), 32'h0);
    check("rst_cycles", cycle_count_o, 32'h0);
    step();
    run_idle(50);
    bus_write(4'hF, EXIT_ADDR, 32'h0000_0001);
    run_idle(4);
    check("pass_done_early", 32'(done_o), 32'h0);
    step();
    check("pass_done", 32'(done_o), 32'h1);
    check("pass_pass", 32'(pass_o), 32'h1);
    check("pass_cycles", cycle_count_o, 32'd51);

    // Failing exit code.
    do_reset(2);
    step();
    run_idle(3);
    bus_write(4'hF, EXIT_ADDR, 32'h0000_0007);
    run_idle(6);
    check("fail_code", 32'(exit_code_o), 32'd3);
    check("fail_pass", 32'(pass_o), 32'h0);
    check("fail_done", 32'(done_o), 32'h1);

    // Partial write and bit0=0 write are ignored.
    do_reset(2);
    step();
    bus_write(4'b0011, EXIT_ADDR, 32'h1);
    bus_write(4'hF, EXIT_ADDR, 32'h2);
    run_idle(8);
    check("ignored_done", 32'(done_o), 32'h0);
    bus_write(4'hF, EXIT_ADDR, 32'h1);
    run_idle(6);
    check("late_exit_done", 32'(done_o), 32'h1);

    // Timeout without an exit write.
    do_reset(2);
    step();
    run_idle(T_CYC + 2);
    check("to_timeout", 32'(timeout_o), 32'h1);
    check("to_done", 32'(done_o), 32'h1);
    check("to_cycles", cycle_count_o, 32'(T_CYC - 1));
    check("to_pass", 32'(pass_o), 32'h0);

    // Exit write on the timeout cycle takes DRAIN.
    do_reset(2);
    step();
    run_idle(T_CYC - 1);
    bus_write(4'hF, EXIT_ADDR, 32'h1);
    run_idle(6);
    check("race_timeout", 32'(timeout_o), 32'h0);
    check("race_done", 32'(done_o), 32'h1);
    check("race_cycles", cycle_count_o, 32'(T_CYC));

    // Reset pulse during DRAIN aborts the run.
    do_reset(2);
    step();
    run_idle(5);
    bus_write(4'hF, EXIT_ADDR, 32'h1);
    run_idle(2);
    do_reset(1);
    check("abort_cycles", cycle_count_o, 32'h0);
    enable_i = 1'b0;
    run_idle(10);
    check("abort_done", 32'(done_o), 32'h0);
    enable_i = 1'b1;

`ifdef SIM_EXIT_CONSOLE_EN
    // Back-to-back console bytes.
    do_reset(2);
    step();
    op_i = 1'b1; we_i = 4'b0001; addr_i = EXIT_ADDR + 32'd4; data_i = 32'h48;
    step();
    check("con_valid0", 32'(char_valid_o), 32'h1);
    check("con_char0", 32'(char_o), 32'h48);
    data_i = 32'h69;
    step();
    check("con_valid1", 32'(char_valid_o), 32'h1);
    check("con_char1", 32'(char_o), 32'h69);
    run_idle(1);
    check("con_valid2", 32'(char_valid_o), 32'h0);
`endif

    // Randomized runs with random enable, traffic and occasional reset.
    for (int r = 0; r < 30; r++) begin
      do_reset($urandom_range(1, 3));
      for (int c = 0; c < $urandom_range(40, 120); c++) begin
        enable_i = ($urandom_range(0, 3) != 0);
        rand_bus();
        rst_i = ($urandom_range(0, 199) == 0);
        step();
      end
      rst_i = 1'b0;
    end

`ifdef SIM_EXIT_CONSOLE_EN
    check("char_q_left", 32'(exp_q.size()), 32'h0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
